ysyx_25030085_ifu: RTL and testbench
====================================

// Module: ysyx_25030085_ifu
// PURPOSE
//  Instruction fetch unit; upstream of the instruction decoder/control stage.
//  Owns the architectural PC and fetches one instruction at a time over a valid/ready memory port.
//  Presents {pc, inst} to the decoder, waits for execute completion, then computes the next PC.
//  Next-PC sources: sequential, branch, jal, jalr, or trap redirect.
// PARAMETERS
//  RESET_PC        32'h8000_0000  PC loaded on reset; the decoder treats pc < this value as not yet valid.
//  TIMEOUT_CYCLES  1024           max cycles in RESP before a fetch fault is raised; must be >= 2.
// PORTS
//  clk             in   1   single clock; all state updates on posedge.
//  rst             in   1   asynchronous, active-high reset.
//  imem_req_valid  out  1   fetch request valid.
//  imem_req_ready  in   1   memory accepts request.
//  imem_req_addr   out  32  fetch address; equals pc.
//  imem_rsp_valid  in   1   read data valid; the memory always accepts responses.
//  imem_rsp_data   in   32  instruction word.
//  imem_rsp_err    in   1   bus error qualifying imem_rsp_valid.
//  inst_valid      out  1   {pc, inst} valid to decoder.
//  inst_ready      in   1   decoder/execute accepts the instruction.
//  pc              out  32  current PC.
//  inst            out  32  held instruction word.
//  exec_done       in   1   one-cycle pulse: the accepted instruction has retired.
//  branch          in   1   branch taken; sampled with exec_done.
//  jump            in   2   01 = jal, 10 = jalr, else none; sampled with exec_done.
//  imm             in   32  immediate; sampled with exec_done.
//  rs1_val         in   32  rs1 value for jalr; sampled with exec_done.
//  redirect_valid  in   1   trap/mret redirect; sampled with exec_done.
//  redirect_pc     in   32  redirect target.
//  fetch_fault     out  1   one-cycle pulse on bus error, timeout or misaligned target.
//  fault_pc        out  32  PC associated with the last fault; holds its value.
// BEHAVIOUR
//  Reset values: state = IDLE, pc = RESET_PC, inst = 32'h0000_0013 (nop), all valid outputs = 0,
//  fetch_fault = 0, fault_pc = 0, timeout counter = 0.
//  Reset mid-transaction abandons the transaction. Any late imem_rsp_valid is ignored unless the FSM is in RESP.
//  FSM:
//   IDLE -> REQ unconditionally on the next cycle.
//   REQ: imem_req_valid = 1 and imem_req_addr is stable until imem_req_ready; on handshake -> RESP, counter cleared.
//   RESP: the counter increments each cycle.
//    rsp_valid & !rsp_err: latch inst, -> HOLD.
//    rsp_valid & rsp_err: fault pulse, fault_pc = pc, -> REQ, same pc (retry).
//    counter == TIMEOUT_CYCLES-1 without rsp_valid: fault pulse, -> REQ.
//   HOLD: inst_valid = 1; pc and inst are stable until inst_ready; on handshake -> EXEC.
//   EXEC: wait for exec_done. On exec_done, latch npc into pc and go to REQ (no IDLE bubble).
//  Fetch latency: min 3 cycles from entering REQ to inst_valid (REQ, RESP, HOLD), with ready/rsp_valid same-cycle.
//  Next-PC priority (all 32-bit, wrap-around modulo 2^32, no overflow flag):
//   redirect_valid     -> redirect_pc
//   jump == 10         -> (rs1_val + imm) & ~32'h1
//   jump == 01 | branch -> pc + imm
//   otherwise          -> pc + 4
//  Misaligned target: npc[1:0] != 0 after masking.
//   Raise the fault pulse with fault_pc = npc, still load pc = npc, then fetch (memory decides).
//  Edge cases:
//   exec_done outside EXEC is ignored.
//   inst_ready outside HOLD has no effect.
//   jump == 11 is treated as none.
//   pc = 32'hFFFF_FFFC with sequential flow wraps to 0.
// STRUCTURE
//  Package ysyx_25030085_pkg:
//   ifu_state_e {IDLE, REQ, RESP, HOLD, EXEC};
//   JUMP_NONE = 2'b00, JUMP_JAL = 2'b01, JUMP_JALR = 2'b10;
//   NOP_INST = 32'h0000_0013.
//  Sub-module ysyx_25030085_npc: purely combinational next-PC mux plus misalignment detection.
//  The FSM, counter and registers stay in the ifu.
// TESTING
//  1. Reset release, memory ready = 1, rsp after 1 cycle with data 32'h00100093
//     -> req_addr 8000_0000; inst_valid with inst 00100093 3 cycles after leaving IDLE.
//  2. exec_done, no jump or branch, at pc 8000_0000 -> next req_addr 8000_0004.
//     exec_done with branch = 1, imm = -8 -> 7FFF_FFFC.
//  3. jalr: rs1_val = 8000_0011, imm = 4 -> pc 8000_0014.
//     jal: imm = 2 -> fetch_fault pulse, fault_pc = pc + 2.
//  4. imem_rsp_err on first response -> one fault pulse, re-request of the same address.
//     Second response OK -> normal HOLD.
//  5. No rsp for TIMEOUT_CYCLES -> fault pulse exactly at the limit, REQ re-issued.
//     Assert rst in RESP -> all outputs return to reset values asynchronously.
//  6. Hold inst_ready = 0 for 5 cycles -> pc and inst stable throughout.
//     exec_done with redirect_valid = 1, redirect_pc = 8000_0100 and jump = 10 -> redirect wins.

Source files
------------

// File: rtl/ysyx_25030085_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_25030085_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        HOLD,
        EXEC
    } ifu_state_e;

    localparam logic [1:0]  JUMP_NONE = 2'b00;
    localparam logic [1:0]  JUMP_JAL  = 2'b01;
    localparam logic [1:0]  JUMP_JALR = 2'b10;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    // A fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25030085_npc.sv
// Combinational next-PC selection with misalignment detection.
module ysyx_25030085_npc
    import ysyx_25030085_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic [1:0]  jump,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] npc,
    output logic        misaligned
);

    // Priority: redirect, jalr, jal/branch, sequential. jump == 11 behaves as none.
    always_comb begin
        npc = pc + 32'd4;
        if (redirect_valid) begin
            npc = redirect_pc;
        end else begin
            case (jump)
                JUMP_JALR:        npc = (rs1_val + imm) & ~32'h1;
                JUMP_JAL:         npc = pc + imm;
                JUMP_NONE, 2'b11: npc = branch ? (pc + imm) : (pc + 32'd4);
            endcase
        end
    end

    assign misaligned = is_misaligned(npc);

endmodule

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: owns the PC, fetches over a valid/ready port and
// hands {pc, inst} to the decoder, then advances the PC on retirement.
module ysyx_25030085_ifu
    import ysyx_25030085_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic [31:0] inst,
    input  logic        exec_done,
    input  logic        branch,
    input  logic [1:0]  jump,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ifu_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;

    logic [31:0]      npc;
    logic             npc_misaligned;

    logic             req_fire, rsp_ok, rsp_bad, rsp_timeout, retire;

    assign req_fire    = (state_q == REQ) && imem_req_ready;
    assign rsp_ok      = (state_q == RESP) && imem_rsp_valid && !imem_rsp_err;
    assign rsp_bad     = (state_q == RESP) && imem_rsp_valid && imem_rsp_err;
    assign rsp_timeout = (state_q == RESP) && !imem_rsp_valid && (cnt_q == CNT_LAST);
    assign retire      = (state_q == EXEC) && exec_done;

    ysyx_25030085_npc u_npc (
        .pc             (pc_q),
        .branch         (branch),
        .jump           (jump),
        .imm            (imm),
        .rs1_val        (rs1_val),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .npc            (npc),
        .misaligned     (npc_misaligned)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (req_fire) state_d = RESP;
            RESP: begin
                if (rsp_ok) begin
                    state_d = HOLD;
                end else if (rsp_bad || rsp_timeout) begin
                    state_d = REQ;
                end
            end
            HOLD: if (inst_ready) state_d = EXEC;
            EXEC: if (exec_done) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        imem_req_valid = (state_q == REQ);
        inst_valid     = (state_q == HOLD);
    end

    // Datapath next values: timeout counter, held instruction, PC and fault capture.
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        cnt_d      = cnt_q;
        fault_d    = 1'b0;
        fault_pc_d = fault_pc_q;
        if (req_fire) begin
            cnt_d = '0;
        end else if (state_q == RESP) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (rsp_ok) begin
            inst_d = imem_rsp_data;
        end
        // Bus error or timeout: retry the same PC.
        if (rsp_bad || rsp_timeout) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
        end
        // A misaligned target is still loaded; the memory decides what to return.
        if (retire) begin
            pc_d = npc;
            if (npc_misaligned) begin
                fault_d    = 1'b1;
                fault_pc_d = npc;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign fetch_fault   = fault_q;
    assign fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Scoreboard bench for the fetch unit: stimulus queues expected requests,
// instructions and faults; monitors pop and compare as the DUT presents them.
module tb_ysyx_25030085_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 1024;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        int          delay;
        logic [31:0] data;
        logic        err;
        logic        silent;
    } rsp_cfg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_rsp_err   = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exec_done = 1'b0;
    logic        branch = 1'b0;
    logic [1:0]  jump = 2'b00;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_val = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_checks = 0;
    int n_fail   = 0;

    rsp_cfg_t    rsp_cfg_q[$];
    logic [31:0] req_exp_q[$];
    logic [63:0] inst_exp_q[$];
    logic [31:0] fault_exp_q[$];

    ysyx_25030085_ifu #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .pc             (pc),
        .inst           (inst),
        .exec_done      (exec_done),
        .branch         (branch),
        .jump           (jump),
        .imm            (imm),
        .rs1_val        (rs1_val),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected (or bound expired)", name);
    endtask

    // Memory model: responds to each accepted request per the next queued descriptor.
    always begin : mem_model
        rsp_cfg_t cfg;
        @(negedge clk);
        if (!rst && imem_req_valid && imem_req_ready && rsp_cfg_q.size() > 0) begin
            cfg = rsp_cfg_q.pop_front();
            if (!cfg.silent) begin
                @(posedge clk); #1;
                repeat (cfg.delay) begin
                    @(posedge clk); #1;
                end
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = cfg.data;
                imem_rsp_err   = cfg.err;
                @(posedge clk); #1;
                imem_rsp_valid = 1'b0;
                imem_rsp_err   = 1'b0;
            end
        end
    end

    // Monitors sample mid-cycle, ahead of the edge where the handshake completes.
    always @(negedge clk) begin : req_mon
        logic [31:0] e;
        if (!rst && imem_req_valid && imem_req_ready) begin
            if (req_exp_q.size() == 0) miss("req_unexpected");
            else begin
                e = req_exp_q.pop_front();
                chk("req_addr", imem_req_addr, e);
            end
        end
    end

    always @(negedge clk) begin : inst_mon
        logic [63:0] e;
        if (!rst && inst_valid && inst_ready) begin
            if (inst_exp_q.size() == 0) miss("inst_unexpected");
            else begin
                e = inst_exp_q.pop_front();
                chk("inst_pc", pc, e[63:32]);
                chk("inst_word", inst, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin : fault_mon
        logic [31:0] e;
        if (!rst && fetch_fault) begin
            if (fault_exp_q.size() == 0) miss("fault_unexpected");
            else begin
                e = fault_exp_q.pop_front();
                chk("fault_pc", fault_pc, e);
            end
        end
    end

    task automatic push_rsp(input int delay, input logic [31:0] data, input logic err,
                            input logic silent);
        rsp_cfg_t c;
        c.delay  = delay;
        c.data   = data;
        c.err    = err;
        c.silent = silent;
        rsp_cfg_q.push_back(c);
    endtask

    // Normal fetch: one request, one good response, one instruction handed over.
    task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] data);
        req_exp_q.push_back(addr);
        push_rsp(0, data, 1'b0, 1'b0);
        inst_exp_q.push_back({addr, data});
    endtask

    task automatic wait_inst(output int cycles);
        cycles = 0;
        while (!inst_valid && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!inst_valid) miss("inst_valid_wait");
    endtask

    task automatic accept();
        int c;
        wait_inst(c);
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
    endtask

    task automatic retire(input logic br, input logic [1:0] jp, input logic [31:0] im,
                          input logic [31:0] rs, input logic rv, input logic [31:0] rp);
        exec_done      = 1'b1;
        branch         = br;
        jump           = jp;
        imm            = im;
        rs1_val        = rs;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk); #1;
        exec_done      = 1'b0;
        branch         = 1'b0;
        jump           = 2'b00;
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        chk({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_inst"}, inst, NOP);
        chk({tag, "_fetch_fault"}, {31'b0, fetch_fault}, 32'h0);
        chk({tag, "_fault_pc"}, fault_pc, 32'h0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c;

        // 1. Reset state, then first fetch latency.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        expect_fetch(RESET_PC, 32'h0010_0093);
        rst = 1'b0;
        wait_inst(c);
        chk("fetch_latency", c, 3);
        accept();

        // 2. Sequential, then taken branch backwards.
        expect_fetch(32'h8000_0004, 32'h0020_8113);
        retire(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        accept();
        expect_fetch(32'h7FFF_FFFC, 32'h0031_0193);
        retire(1'b1, 2'b00, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h0);
        accept();

        // 3. jalr clears bit 0; jal to a misaligned target faults but still fetches.
        expect_fetch(32'h8000_0014, 32'h0041_8213);
        retire(1'b1, 2'b10, 32'h4, 32'h8000_0011, 1'b0, 32'h0);
        accept();
        fault_exp_q.push_back(32'h8000_0016);
        expect_fetch(32'h8000_0016, 32'h0052_0293);
        retire(1'b0, 2'b01, 32'h2, 32'h0, 1'b0, 32'h0);
        accept();

        // 4. Bus error on first response, retry of the same address succeeds.
        req_exp_q.push_back(32'h8000_0018);
        push_rsp(0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        fault_exp_q.push_back(32'h8000_0018);
        expect_fetch(32'h8000_0018, 32'h0062_8313);
        retire(1'b0, 2'b01, 32'h2, 32'h0, 1'b0, 32'h0);
        accept();

        // 5. jump == 11 acts as none; no response until the timeout fires.
        req_exp_q.push_back(32'h8000_001C);
        push_rsp(0, 32'h0, 1'b0, 1'b1);
        fault_exp_q.push_back(32'h8000_001C);
        expect_fetch(32'h8000_001C, 32'h0073_0393);
        retire(1'b0, 2'b11, 32'h100, 32'h0, 1'b0, 32'h0);
        c = 0;
        while (!fetch_fault && c < TIMEOUT + 100) begin
            @(posedge clk); #1;
            c++;
        end
        // One REQ cycle plus TIMEOUT cycles in RESP.
        chk("timeout_cycles", c, TIMEOUT + 1);
        accept();

        // Asynchronous reset in the middle of RESP.
        req_exp_q.push_back(32'h8000_0020);
        push_rsp(0, 32'h0, 1'b0, 1'b1);
        retire(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_pc", pc, 32'h8000_0020);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");

        // 6. Decoder stall: pc and inst hold; stray exec_done in HOLD is ignored.
        expect_fetch(RESET_PC, 32'h0083_8413);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_inst(c);
        for (int i = 0; i < 5; i++) begin
            chk("stall_pc", pc, RESET_PC);
            chk("stall_inst", inst, 32'h0083_8413);
            exec_done      = (i == 2);
            redirect_valid = (i == 2);
            redirect_pc    = 32'h0000_1234;
            @(posedge clk); #1;
            exec_done      = 1'b0;
            redirect_valid = 1'b0;
        end
        chk("stall_valid", {31'b0, inst_valid}, 32'h1);
        accept();

        // Redirect beats jalr.
        expect_fetch(32'h8000_0100, 32'h0094_0493);
        retire(1'b1, 2'b10, 32'h8, 32'h0000_2000, 1'b1, 32'h8000_0100);
        accept();

        // Sequential flow from the top of the address space wraps to zero.
        expect_fetch(32'hFFFF_FFFC, 32'h00A4_8513);
        retire(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        accept();
        expect_fetch(32'h0000_0000, 32'h00B5_0593);
        retire(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        accept();

        repeat (4) @(posedge clk);
        #1;
        chk("req_queue_drained", req_exp_q.size(), 0);
        chk("inst_queue_drained", inst_exp_q.size(), 0);
        chk("fault_queue_drained", fault_exp_q.size(), 0);
        chk("rsp_queue_drained", rsp_cfg_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
